// File: rtl/qsic_pkg.sv
// qsic_pkg -- definitions shared by the QSIC device emulations.
//   CSR bit positions and the CSR writable mask, the interrupt FSM state type,
//   a constant-foldable clog2 and the register-index width helper.
package qsic_pkg;

  localparam int          CSR_READY_BIT = 7;
  localparam int          CSR_IE_BIT    = 6;
  localparam logic [15:0] CSR_WMASK     = 16'o000100;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_REQ
  } irq_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Width of the word index into a bank of nregs 16-bit registers.
  function automatic int idx_width(input int nregs);
    return clog2(nregs);
  endfunction

endpackage

// File: rtl/switch_register_bank_if.sv
// switch_register_bank_if -- QBUS-side signals of an I/O-page register device.
//   RAL[12:0]      latched byte address       RBS7        I/O page select
//   RDL[15:0]      bus data in                TDL[15:0]   data out / vector
//   addr_match     device decoded             assert_vector interrupt ack
//   write_pulse    write strobe               write_byte  byte write (WTBT)
//   irq            interrupt request
// master = bus side, slave = device side.
interface switch_register_bank_if;

  logic [12:0] RAL;
  logic        RBS7;
  logic [15:0] RDL;
  logic [15:0] TDL;
  logic        addr_match;
  logic        assert_vector;
  logic        write_pulse;
  logic        write_byte;
  logic        irq;

  modport master (
    output RAL, RBS7, RDL, assert_vector, write_pulse, write_byte,
    input  TDL, addr_match, irq
  );

  modport slave (
    input  RAL, RBS7, RDL, assert_vector, write_pulse, write_byte,
    output TDL, addr_match, irq
  );

endinterface

// File: rtl/qbus_byte_reg.sv
// qbus_byte_reg -- 16-bit register with independent low/high byte enables.
//   qclk, reset_n  clock, asynchronous active-low reset (loads RESET_VAL)
//   we_lo, we_hi   load d[7:0] / d[15:8] on the rising qclk edge
//   d, q           data in / register contents
module qbus_byte_reg #(
  parameter logic [15:0] RESET_VAL = 16'o000777
) (
  input  logic        qclk,
  input  logic        reset_n,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the reset branch gives each flop a defined power-up value.
  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else begin
      if (we_lo) q[7:0]  <= d[7:0];
      if (we_hi) q[15:8] <= d[15:8];
    end
  end

endmodule

// File: rtl/switch_register_bank.sv
// switch_register_bank -- NREGS word registers on the QBUS I/O page, reg 0 is
// a CSR (bit 7 READY read-only, bit 6 IE), regs 1..NREGS-1 are data registers
// (byte writable) whose writes set READY. READY && IE raises irq; the vector
// is supplied on TDL during assert_vector.
//   qclk, reset_n  clock, asynchronous active-low reset
//   bus            QBUS signals (slave modport)
//   addr[17:0]     base byte address, aligned to 2*NREGS
//   regs_out       all register contents, reg i at [16i+15:16i]
module switch_register_bank
  import qsic_pkg::*;
#(
  parameter int          NREGS     = 4,
  parameter logic [15:0] RESET_VAL = 16'o000777,
  parameter logic [8:0]  VECTOR    = 9'o300
) (
  input  logic                   qclk,
  input  logic                   reset_n,
  switch_register_bank_if.slave  bus,
  input  logic [17:0]            addr,
  output logic [16*NREGS-1:0]    regs_out
);

  localparam int AW = clog2(2 * NREGS);  // byte-offset bits within the bank
  localparam int IW = idx_width(NREGS);

  logic [IW-1:0] idx;
  logic [15:0]   regs [NREGS];
  logic          wp_prev;
  logic          rst_done;
  logic          write_fire;
  logic          lo_hit;
  logic          hi_hit;
  logic          data_fire;
  logic          csr_clr;
  logic          ready;
  logic          ie;
  logic          arm;
  irq_state_t    state_q;
  irq_state_t    state_d;

  assign idx            = bus.RAL[AW-1:1];
  assign bus.addr_match = bus.RBS7 && (bus.RAL[12:AW] == addr[12:AW]);

  // Base-address bits below the bank size and above the 8 KB I/O page carry
  // no decode information.
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[17:13], addr[AW-1:0]};

  // Edge detector for the write strobe. rst_done keeps the first cycle after
  // reset release as a sampling-only cycle, so a strobe that straddles reset
  // is never taken as a fresh write.
  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      wp_prev  <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      wp_prev  <= bus.write_pulse;
      rst_done <= 1'b1;
    end
  end

  assign write_fire = bus.write_pulse && !wp_prev && rst_done && bus.addr_match;
  assign lo_hit     = !bus.write_byte || !bus.RAL[0];
  assign hi_hit     = !bus.write_byte ||  bus.RAL[0];
  assign data_fire  = write_fire && (idx != '0);
  assign csr_clr    = write_fire && (idx == '0) && lo_hit;

  // CSR: READY, IE and the interrupt arm bit (set on READY 0->1, cleared by
  // acknowledge). Set is applied last so it wins over a same-cycle clear.
  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b0;
      ie    <= 1'b0;
      arm   <= 1'b0;
    end else begin
      if (state_q == IRQ_REQ && bus.assert_vector) arm <= 1'b0;
      if (csr_clr) begin
        ready <= 1'b0;
        ie    <= |(bus.RDL & CSR_WMASK);
      end
      if (data_fire) begin
        ready <= 1'b1;
        if (!ready) arm <= 1'b1;
      end
    end
  end

  always_comb begin
    regs[0]                = '0;
    regs[0][CSR_READY_BIT] = ready;
    regs[0][CSR_IE_BIT]    = ie;
  end

  for (genvar g = 1; g < NREGS; g++) begin : g_data
    qbus_byte_reg #(
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .qclk    (qclk),
      .reset_n (reset_n),
      .we_lo   (data_fire && (idx == IW'(g)) && lo_hit),
      .we_hi   (data_fire && (idx == IW'(g)) && hi_hit),
      .d       (bus.RDL),
      .q       (regs[g])
    );
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_out[16*g +: 16] = regs[g];
  end

  // Interrupt FSM: state register / next state / output.
  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) state_q <= IRQ_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (ready && ie && arm)                  state_d = IRQ_REQ;
      IRQ_REQ:  if (bus.assert_vector || !ie || !ready)  state_d = IRQ_IDLE;
      default:                                           state_d = IRQ_IDLE;
    endcase
  end

  always_comb begin
    bus.irq = (state_q == IRQ_REQ);
  end

  assign bus.TDL = bus.assert_vector ? {7'b0, VECTOR[8:2], 2'b00} : regs[idx];

endmodule

// File: tb/tb_switch_register_bank.sv
`timescale 1ns/1ps
module tb_switch_register_bank;

  logic        qclk;
  logic        reset_n;
  logic [17:0] addr;
  logic [63:0] regs_out;

  int checks   = 0;
  int failures = 0;

  switch_register_bank_if bus ();

  switch_register_bank #(
    .NREGS     (4),
    .RESET_VAL (16'o000777),
    .VECTOR    (9'o300)
  ) dut (
    .qclk     (qclk),
    .reset_n  (reset_n),
    .bus      (bus),
    .addr     (addr),
    .regs_out (regs_out)
  );

  initial qclk = 1'b0;
  always #25 qclk = ~qclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic set_addr(input logic [17:0] a);
    bus.RAL  = a[12:0];
    bus.RBS7 = &a[17:13];
  endtask

  task automatic read_chk(input string tag, input logic [17:0] a, input logic [15:0] exp);
    set_addr(a);
    #1;
    check(tag, {16'b0, bus.TDL}, {16'b0, exp});
  endtask

  // Strobe held for 'hold' cycles; RDL is scrambled after the first edge so a
  // repeated write would be visible.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input logic bytew, input int hold);
    @(negedge qclk);
    set_addr(a);
    bus.RDL         = d;
    bus.write_byte  = bytew;
    bus.write_pulse = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge qclk);
      bus.RDL = ~d;
    end
    bus.write_pulse = 1'b0;
    @(negedge qclk);
  endtask

  initial begin
    addr              = 18'o777560;
    reset_n           = 1'b0;
    bus.RAL           = '0;
    bus.RBS7          = 1'b0;
    bus.RDL           = '0;
    bus.assert_vector = 1'b0;
    bus.write_pulse   = 1'b0;
    bus.write_byte    = 1'b0;
    repeat (3) @(negedge qclk);

    // Reset state
    read_chk("rst_reg1", 18'o777562, 16'o000777);
    read_chk("rst_reg2", 18'o777564, 16'o000777);
    read_chk("rst_reg3", 18'o777566, 16'o000777);
    read_chk("rst_csr",  18'o777560, 16'o000000);
    check("rst_irq", {31'b0, bus.irq}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge qclk);

    // Word write, long strobe
    do_write(18'o777562, 16'o123456, 1'b0, 5);
    read_chk("word_reg1", 18'o777562, 16'o123456);
    read_chk("word_csr_ready", 18'o777560, 16'o000200);

    // Byte writes
    do_write(18'o777565, 16'o177400, 1'b1, 1);
    read_chk("byte_hi_reg2", 18'o777564, 16'o177777);
    do_write(18'o777564, 16'o000000, 1'b1, 1);
    read_chk("byte_lo_reg2", 18'o777564, 16'o177400);

    // Interrupt path
    do_write(18'o777560, 16'o000100, 1'b0, 1);
    read_chk("csr_ie_only", 18'o777560, 16'o000100);
    check("irq_before", {31'b0, bus.irq}, 32'd0);
    do_write(18'o777566, 16'o000042, 1'b0, 1);
    check("irq_raised", {31'b0, bus.irq}, 32'd1);
    bus.assert_vector = 1'b1;
    #1;
    check("vector_tdl", {16'b0, bus.TDL}, {16'b0, 16'o000300});
    @(negedge qclk);
    bus.assert_vector = 1'b0;
    check("irq_ack_fall", {31'b0, bus.irq}, 32'd0);
    do_write(18'o777566, 16'o000043, 1'b0, 1);
    repeat (2) @(negedge qclk);
    check("irq_no_rearm", {31'b0, bus.irq}, 32'd0);
    read_chk("csr_ready_ie", 18'o777560, 16'o000300);

    // Address decode
    set_addr(18'o777570);
    #1;
    check("match_out_of_bank", {31'b0, bus.addr_match}, 32'd0);
    set_addr(18'o777566);
    #1;
    check("match_top_reg", {31'b0, bus.addr_match}, 32'd1);
    bus.RAL  = 13'o17562;
    bus.RBS7 = 1'b0;
    #1;
    check("match_no_bs7", {31'b0, bus.addr_match}, 32'd0);
    do_write(18'o777570, 16'o111111, 1'b0, 1);
    check("nomatch_regs", regs_out[63:32], {16'o000043, 16'o177400});
    check("nomatch_reg1", {16'b0, regs_out[31:16]}, {16'b0, 16'o123456});

    // Reset mid-strobe with irq pending
    do_write(18'o777560, 16'o000000, 1'b0, 1);
    do_write(18'o777560, 16'o000100, 1'b0, 1);
    do_write(18'o777562, 16'o000001, 1'b0, 1);
    check("irq_rearmed", {31'b0, bus.irq}, 32'd1);
    @(negedge qclk);
    set_addr(18'o777564);
    bus.RDL         = 16'o012345;
    bus.write_byte  = 1'b0;
    bus.write_pulse = 1'b1;
    #5 reset_n = 1'b0;
    #1;
    check("rst_mid_irq", {31'b0, bus.irq}, 32'd0);
    check("rst_mid_csr", {16'b0, regs_out[15:0]}, 32'd0);
    check("rst_mid_data", regs_out[63:32], {16'o000777, 16'o000777});
    check("rst_mid_reg1", {16'b0, regs_out[31:16]}, {16'b0, 16'o000777});
    @(negedge qclk);
    reset_n = 1'b1;
    repeat (3) @(negedge qclk);
    check("rel_no_write", {16'b0, regs_out[47:32]}, {16'b0, 16'o000777});
    check("rel_no_ready", {16'b0, regs_out[15:0]}, 32'd0);
    bus.write_pulse = 1'b0;
    @(negedge qclk);

    // Normal operation after reset
    do_write(18'o777564, 16'o012345, 1'b0, 2);
    read_chk("post_rst_reg2", 18'o777564, 16'o012345);
    read_chk("post_rst_csr", 18'o777560, 16'o000200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
